// File: rtl/spi_master_ctrl_pkg.sv
// Shared definitions for the SPI master sequencer.
// - state_e      : FSM state encoding (Idle/Setup/Xfer/Hold = 0..3)
// - Def*         : default transfer width and chip-select timing, also used by integration tops
// - last_strobe  : true when a strobe counter is about to reach its target
package spi_master_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSetup = 2'd1,
    StXfer  = 2'd2,
    StHold  = 2'd3
  } state_e;

  localparam int unsigned DefWidth    = 8;
  localparam int unsigned DefCsSetup  = 1;
  localparam int unsigned DefCsHold   = 1;
  localparam int unsigned CsCntW      = 4;

  // The strobe being processed now is number cnt+1; it is the last one when that equals target.
  function automatic logic last_strobe(input logic [CsCntW-1:0] cnt, input int unsigned target);
    return (32'(cnt) + 32'd1) == target;
  endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Transmit/receive shift pair for the SPI master.
// Ports:
//   clk, rst_n     : system clock, asynchronous active-low reset
//   load_i         : capture data_i and present its first bit on mosi_o
//   shift_out_i    : advance mosi_o to the next transmit bit (falling serial edge)
//   shift_in_i     : shift miso_i into the receive register (rising serial edge)
//   data_i         : parallel word to transmit
//   miso_i         : serial data in
//   mosi_o         : serial data out, registered, holds its value between shifts
//   rx_word_o      : receive shift register contents
module spi_shift_reg
  import spi_master_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH     = DefWidth,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             shift_out_i,
  input  logic             shift_in_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             miso_i,
  output logic             mosi_o,
  output logic [WIDTH-1:0] rx_word_o
);

  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic             mosi_q, mosi_d;
  logic [WIDTH-1:0] tx_src;

  always_comb begin
    tx_d   = tx_q;
    rx_d   = rx_q;
    mosi_d = mosi_q;
    // A load and a shift-out both pop one bit; they differ only in the source word.
    tx_src = load_i ? data_i : tx_q;
    if (load_i || shift_out_i) begin
      if (MSB_FIRST) begin
        mosi_d = tx_src[WIDTH-1];
        tx_d   = {tx_src[WIDTH-2:0], 1'b0};
      end else begin
        mosi_d = tx_src[0];
        tx_d   = {1'b0, tx_src[WIDTH-1:1]};
      end
    end
    if (shift_in_i) begin
      if (MSB_FIRST) begin
        rx_d = {rx_q[WIDTH-2:0], miso_i};
      end else begin
        rx_d = {miso_i, rx_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q   <= '0;
      rx_q   <= '0;
      mosi_q <= 1'b0;
    end else begin
      tx_q   <= tx_d;
      rx_q   <= rx_d;
      mosi_q <= mosi_d;
    end
  end

  assign mosi_o    = mosi_q;
  assign rx_word_o = rx_q;

endmodule

// File: rtl/spi_master_ctrl.sv
// Mode-0 SPI master sequencer driven by an external serial clock generator.
// Ports:
//   clk, rst_n                  : system clock, asynchronous active-low reset
//   sclk_in                     : free-running serial clock
//   sclk_pos_edge/sclk_neg_edge : one-cycle strobes marking sclk_in rise/fall
//   tx_valid, tx_data, tx_ready : transmit request handshake
//   rx_valid, rx_data           : received word, rx_valid is a one-cycle pulse
//   busy                        : high whenever a transfer is in progress
//   cs_n                        : chip select, active low
//   sclk_out                    : serial clock gated to the data phase
//   mosi, miso                  : serial data out / in
module spi_master_ctrl
  import spi_master_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH     = DefWidth,
  parameter int unsigned CS_SETUP  = DefCsSetup,
  parameter int unsigned CS_HOLD   = DefCsHold,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclk_in,
  input  logic             sclk_pos_edge,
  input  logic             sclk_neg_edge,
  input  logic             tx_valid,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_ready,
  output logic             rx_valid,
  output logic [WIDTH-1:0] rx_data,
  output logic             busy,
  output logic             cs_n,
  output logic             sclk_out,
  output logic             mosi,
  input  logic             miso
);

  localparam int unsigned BitCntW = $clog2(WIDTH + 1);

  state_e              state_q;
  logic                cs_n_q;
  logic                xfer_active_q;
  logic                tx_ready_q;
  logic                rx_valid_q;
  logic                busy_q;
  logic [WIDTH-1:0]    rx_data_q;
  logic [BitCntW-1:0]  bit_cnt_q;
  logic [CsCntW-1:0]   setup_cnt_q;
  logic [CsCntW-1:0]   hold_cnt_q;

  logic                pos_stb;
  logic                neg_stb;
  logic                handshake;
  logic                bits_done;
  logic                shift_out;
  logic                shift_in;
  logic [WIDTH-1:0]    rx_word;

  always_comb begin
    pos_stb   = sclk_pos_edge;
    // A coincident pos strobe wins; the neg strobe is dropped.
    neg_stb   = sclk_neg_edge & ~sclk_pos_edge;
    handshake = (state_q == StIdle) & tx_valid & tx_ready_q;
    bits_done = (bit_cnt_q == BitCntW'(WIDTH));
    shift_in  = (state_q == StXfer) & pos_stb;
    shift_out = (state_q == StXfer) & neg_stb & ~bits_done;
  end

  spi_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (handshake),
    .shift_out_i (shift_out),
    .shift_in_i  (shift_in),
    .data_i      (tx_data),
    .miso_i      (miso),
    .mosi_o      (mosi),
    .rx_word_o   (rx_word)
  );

  // xfer_active_q only changes on neg strobes, i.e. while sclk_in is low, so the gated
  // clock never produces a runt pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cs_n_q        <= 1'b1;
      xfer_active_q <= 1'b0;
      tx_ready_q    <= 1'b1;
      rx_valid_q    <= 1'b0;
      busy_q        <= 1'b0;
      rx_data_q     <= '0;
      bit_cnt_q     <= '0;
      setup_cnt_q   <= '0;
      hold_cnt_q    <= '0;
    end else begin
      rx_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (handshake) begin
            cs_n_q      <= 1'b0;
            tx_ready_q  <= 1'b0;
            busy_q      <= 1'b1;
            setup_cnt_q <= '0;
            state_q     <= StSetup;
          end
        end
        StSetup: begin
          if (neg_stb) begin
            if (last_strobe(setup_cnt_q, CS_SETUP)) begin
              xfer_active_q <= 1'b1;
              bit_cnt_q     <= '0;
              setup_cnt_q   <= '0;
              state_q       <= StXfer;
            end else begin
              setup_cnt_q <= setup_cnt_q + CsCntW'(1);
            end
          end
        end
        StXfer: begin
          if (pos_stb) begin
            bit_cnt_q <= bit_cnt_q + BitCntW'(1);
          end else if (neg_stb && bits_done) begin
            xfer_active_q <= 1'b0;
            rx_data_q     <= rx_word;
            rx_valid_q    <= 1'b1;
            hold_cnt_q    <= '0;
            state_q       <= StHold;
          end
        end
        StHold: begin
          if (neg_stb) begin
            if (last_strobe(hold_cnt_q, CS_HOLD)) begin
              cs_n_q     <= 1'b1;
              tx_ready_q <= 1'b1;
              busy_q     <= 1'b0;
              hold_cnt_q <= '0;
              state_q    <= StIdle;
            end else begin
              hold_cnt_q <= hold_cnt_q + CsCntW'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign tx_ready = tx_ready_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign busy     = busy_q;
  assign cs_n     = cs_n_q;
  assign sclk_out = sclk_in & xfer_active_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
module tb_spi_master_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Serial clock generator model: 32-clk half period, strobes coincide with the new level.
  logic       sclk, pos_stb, neg_stb;
  logic [4:0] gen_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gen_cnt <= '0;
      sclk    <= 1'b0;
      pos_stb <= 1'b0;
      neg_stb <= 1'b0;
    end else begin
      pos_stb <= 1'b0;
      neg_stb <= 1'b0;
      gen_cnt <= gen_cnt + 5'd1;
      if (gen_cnt == 5'd31) begin
        sclk    <= ~sclk;
        pos_stb <= ~sclk;
        neg_stb <= sclk;
      end
    end
  end

  // Instance 0: defaults. Instance 1: LSB first. Instance 2: CS_SETUP=3, CS_HOLD=2.
  logic       tx_valid [3];
  logic [7:0] tx_data  [3];
  logic       miso     [3];
  logic       tx_ready_w [3];
  logic       rx_valid_w [3];
  logic [7:0] rx_data_w  [3];
  logic       busy_w     [3];
  logic       cs_n_w     [3];
  logic       sclk_out_w [3];
  logic       mosi_w     [3];

  spi_master_ctrl #(.WIDTH(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .sclk_in(sclk), .sclk_pos_edge(pos_stb), .sclk_neg_edge(neg_stb),
    .tx_valid(tx_valid[0]), .tx_data(tx_data[0]), .tx_ready(tx_ready_w[0]),
    .rx_valid(rx_valid_w[0]), .rx_data(rx_data_w[0]), .busy(busy_w[0]), .cs_n(cs_n_w[0]),
    .sclk_out(sclk_out_w[0]), .mosi(mosi_w[0]), .miso(miso[0])
  );

  spi_master_ctrl #(.WIDTH(8), .MSB_FIRST(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .sclk_in(sclk), .sclk_pos_edge(pos_stb), .sclk_neg_edge(neg_stb),
    .tx_valid(tx_valid[1]), .tx_data(tx_data[1]), .tx_ready(tx_ready_w[1]),
    .rx_valid(rx_valid_w[1]), .rx_data(rx_data_w[1]), .busy(busy_w[1]), .cs_n(cs_n_w[1]),
    .sclk_out(sclk_out_w[1]), .mosi(mosi_w[1]), .miso(miso[1])
  );

  spi_master_ctrl #(.WIDTH(8), .CS_SETUP(3), .CS_HOLD(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .sclk_in(sclk), .sclk_pos_edge(pos_stb), .sclk_neg_edge(neg_stb),
    .tx_valid(tx_valid[2]), .tx_data(tx_data[2]), .tx_ready(tx_ready_w[2]),
    .rx_valid(rx_valid_w[2]), .rx_data(rx_data_w[2]), .busy(busy_w[2]), .cs_n(cs_n_w[2]),
    .sclk_out(sclk_out_w[2]), .mosi(mosi_w[2]), .miso(miso[2])
  );

  int total = 0;
  int bad = 0;

  // Observations gathered by run_xfer.
  int         r_rises, r_rx_pulses, r_setup_negs, r_hold_negs, r_ready_bad, r_sclk_bad;
  logic [7:0] r_rx_word, r_mosi_seq;
  bit         r_first_ok, r_timeout, r_end_ready, r_end_sclk;

  // Runs one transfer on instance id; returns at the first negedge where cs_n is high again.
  // r_mosi_seq holds mosi at each sclk_out rise, first bit in the MSB position.
  task automatic run_xfer(input int id, input logic [7:0] data, input logic [7:0] pat,
                          input bit loop, input bit keep_valid, input logic [7:0] next_data);
    int       guard;
    logic     prev;
    logic [2:0] idx;
    bit       rise;
    r_rises = 0; r_rx_pulses = 0; r_setup_negs = 0; r_hold_negs = 0;
    r_ready_bad = 0; r_sclk_bad = 0; r_rx_word = 8'h00; r_mosi_seq = 8'h00; r_timeout = 0;
    guard = 0;
    while (tx_ready_w[id] !== 1'b1 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    tx_valid[id] = 1'b1;
    tx_data[id]  = data;
    @(negedge clk);
    r_first_ok = (cs_n_w[id] === 1'b0) && (tx_ready_w[id] === 1'b0) && (busy_w[id] === 1'b1);
    if (keep_valid) tx_data[id] = next_data;
    else tx_valid[id] = 1'b0;
    prev  = 1'b0;
    guard = 0;
    while (cs_n_w[id] === 1'b0 && guard < 5000) begin
      rise = (sclk_out_w[id] === 1'b1) && (prev === 1'b0);
      idx  = 3'(r_rises);
      miso[id] = loop ? mosi_w[id] : pat[idx];
      if (rise) begin
        r_mosi_seq = {r_mosi_seq[6:0], mosi_w[id]};
        r_rises++;
      end
      prev = sclk_out_w[id];
      if (neg_stb === 1'b1) begin
        if (r_rises == 0) r_setup_negs++;
        else if (r_rises >= 8) r_hold_negs++;
      end
      if (rx_valid_w[id] === 1'b1) begin
        r_rx_pulses++;
        r_rx_word = rx_data_w[id];
      end
      if (tx_ready_w[id] === 1'b1) r_ready_bad++;
      if (sclk_out_w[id] === 1'b1 && r_rx_pulses > 0) r_sclk_bad++;
      @(negedge clk);
      guard++;
    end
    r_timeout   = (guard >= 5000);
    r_end_ready = tx_ready_w[id];
    r_end_sclk  = sclk_out_w[id];
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      total++; if (cs_n_w[i] !== 1'b1) begin bad++; $display("FAIL reset_cs_n[%0d] got=%b want=1", i, cs_n_w[i]); end
      total++; if (tx_ready_w[i] !== 1'b1) begin bad++; $display("FAIL reset_tx_ready[%0d] got=%b want=1", i, tx_ready_w[i]); end
      total++; if (busy_w[i] !== 1'b0) begin bad++; $display("FAIL reset_busy[%0d] got=%b want=0", i, busy_w[i]); end
      total++; if (rx_valid_w[i] !== 1'b0) begin bad++; $display("FAIL reset_rx_valid[%0d] got=%b want=0", i, rx_valid_w[i]); end
      total++; if (rx_data_w[i] !== 8'h00) begin bad++; $display("FAIL reset_rx_data[%0d] got=%h want=00", i, rx_data_w[i]); end
      total++; if (mosi_w[i] !== 1'b0) begin bad++; $display("FAIL reset_mosi[%0d] got=%b want=0", i, mosi_w[i]); end
      total++; if (sclk_out_w[i] !== 1'b0) begin bad++; $display("FAIL reset_sclk_out[%0d] got=%b want=0", i, sclk_out_w[i]); end
    end
  endtask

  task automatic test_loopback();
    run_xfer(0, 8'hA5, 8'h00, 1'b1, 1'b0, 8'h00);
    total++; if (r_timeout) begin bad++; $display("FAIL a5_timeout got=1 want=0"); end
    total++; if (!r_first_ok) begin bad++; $display("FAIL a5_handshake got=0 want=1"); end
    total++; if (r_rises !== 8) begin bad++; $display("FAIL a5_rises got=%0d want=8", r_rises); end
    total++; if (r_rx_pulses !== 1) begin bad++; $display("FAIL a5_rx_pulses got=%0d want=1", r_rx_pulses); end
    total++; if (r_rx_word !== 8'hA5) begin bad++; $display("FAIL a5_rx_word got=%h want=a5", r_rx_word); end
    total++; if (rx_data_w[0] !== 8'hA5) begin bad++; $display("FAIL a5_rx_held got=%h want=a5", rx_data_w[0]); end
    total++; if (r_mosi_seq !== 8'hA5) begin bad++; $display("FAIL a5_mosi_seq got=%h want=a5", r_mosi_seq); end
    total++; if (r_setup_negs !== 1) begin bad++; $display("FAIL a5_setup_negs got=%0d want=1", r_setup_negs); end
    // finishing strobe plus CS_HOLD=1
    total++; if (r_hold_negs !== 2) begin bad++; $display("FAIL a5_hold_negs got=%0d want=2", r_hold_negs); end
    total++; if (r_ready_bad !== 0) begin bad++; $display("FAIL a5_ready_low got=%0d want=0", r_ready_bad); end
    total++; if (r_end_ready !== 1'b1) begin bad++; $display("FAIL a5_end_ready got=%b want=1", r_end_ready); end
  endtask

  task automatic test_miso_high();
    run_xfer(0, 8'h00, 8'hFF, 1'b0, 1'b0, 8'h00);
    total++; if (r_rises !== 8) begin bad++; $display("FAIL ff_rises got=%0d want=8", r_rises); end
    total++; if (r_rx_word !== 8'hFF) begin bad++; $display("FAIL ff_rx_word got=%h want=ff", r_rx_word); end
    total++; if (r_mosi_seq !== 8'h00) begin bad++; $display("FAIL ff_mosi_seq got=%h want=00", r_mosi_seq); end
  endtask

  task automatic test_lsb_first();
    run_xfer(1, 8'h01, 8'h01, 1'b0, 1'b0, 8'h00);
    total++; if (r_rises !== 8) begin bad++; $display("FAIL lsb_rises got=%0d want=8", r_rises); end
    total++; if (r_rx_word !== 8'h01) begin bad++; $display("FAIL lsb_rx_word got=%h want=01", r_rx_word); end
    // time order 1,0,0,0,0,0,0,0
    total++; if (r_mosi_seq !== 8'h80) begin bad++; $display("FAIL lsb_mosi_seq got=%h want=80", r_mosi_seq); end
    total++; if (r_rx_pulses !== 1) begin bad++; $display("FAIL lsb_rx_pulses got=%0d want=1", r_rx_pulses); end
  endtask

  task automatic test_cs_timing();
    run_xfer(2, 8'h96, 8'h00, 1'b1, 1'b0, 8'h00);
    total++; if (r_timeout) begin bad++; $display("FAIL cs_timeout got=1 want=0"); end
    total++; if (r_setup_negs !== 3) begin bad++; $display("FAIL cs_setup_negs got=%0d want=3", r_setup_negs); end
    total++; if (r_hold_negs !== 3) begin bad++; $display("FAIL cs_hold_negs got=%0d want=3", r_hold_negs); end
    total++; if (r_sclk_bad !== 0) begin bad++; $display("FAIL cs_sclk_in_hold got=%0d want=0", r_sclk_bad); end
    total++; if (r_end_sclk !== 1'b0) begin bad++; $display("FAIL cs_sclk_idle got=%b want=0", r_end_sclk); end
    total++; if (r_rises !== 8) begin bad++; $display("FAIL cs_rises got=%0d want=8", r_rises); end
    total++; if (r_rx_word !== 8'h96) begin bad++; $display("FAIL cs_rx_word got=%h want=96", r_rx_word); end
  endtask

  task automatic test_back_to_back();
    run_xfer(0, 8'h3C, 8'h00, 1'b1, 1'b1, 8'hC3);
    total++; if (r_rx_word !== 8'h3C) begin bad++; $display("FAIL b2b_first_rx got=%h want=3c", r_rx_word); end
    total++; if (r_ready_bad !== 0) begin bad++; $display("FAIL b2b_first_ready got=%0d want=0", r_ready_bad); end
    total++; if (r_end_ready !== 1'b1) begin bad++; $display("FAIL b2b_gap_ready got=%b want=1", r_end_ready); end
    run_xfer(0, 8'hC3, 8'h00, 1'b1, 1'b0, 8'h00);
    total++; if (!r_first_ok) begin bad++; $display("FAIL b2b_second_start got=0 want=1"); end
    total++; if (r_rx_word !== 8'hC3) begin bad++; $display("FAIL b2b_second_rx got=%h want=c3", r_rx_word); end
    total++; if (r_rx_pulses !== 1) begin bad++; $display("FAIL b2b_second_pulses got=%0d want=1", r_rx_pulses); end
    total++; if (r_ready_bad !== 0) begin bad++; $display("FAIL b2b_second_ready got=%0d want=0", r_ready_bad); end
  endtask

  task automatic test_reset_abort();
    int   guard = 0;
    int   rises = 0;
    int   pulses = 0;
    logic prev = 1'b0;
    while (tx_ready_w[0] !== 1'b1 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    tx_valid[0] = 1'b1;
    tx_data[0]  = 8'h77;
    @(negedge clk);
    tx_valid[0] = 1'b0;
    guard = 0;
    while (rises < 4 && guard < 5000) begin
      miso[0] = mosi_w[0];
      if (sclk_out_w[0] === 1'b1 && prev === 1'b0) rises++;
      prev = sclk_out_w[0];
      if (rises < 4) begin
        @(negedge clk);
        guard++;
      end
    end
    total++; if (rises !== 4) begin bad++; $display("FAIL abort_reach_rise4 got=%0d want=4", rises); end
    rst_n = 1'b0;
    #1;
    total++; if (cs_n_w[0] !== 1'b1) begin bad++; $display("FAIL abort_cs_n got=%b want=1", cs_n_w[0]); end
    total++; if (sclk_out_w[0] !== 1'b0) begin bad++; $display("FAIL abort_sclk_out got=%b want=0", sclk_out_w[0]); end
    total++; if (tx_ready_w[0] !== 1'b1) begin bad++; $display("FAIL abort_tx_ready got=%b want=1", tx_ready_w[0]); end
    total++; if (busy_w[0] !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy_w[0]); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (1500) begin
      @(negedge clk);
      if (rx_valid_w[0] === 1'b1) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL abort_no_rx_valid got=%0d want=0", pulses); end
    run_xfer(0, 8'h5A, 8'h00, 1'b1, 1'b0, 8'h00);
    total++; if (r_rx_word !== 8'h5A) begin bad++; $display("FAIL after_abort_rx got=%h want=5a", r_rx_word); end
    total++; if (r_rx_pulses !== 1) begin bad++; $display("FAIL after_abort_pulses got=%0d want=1", r_rx_pulses); end
    total++; if (r_rises !== 8) begin bad++; $display("FAIL after_abort_rises got=%0d want=8", r_rises); end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      tx_valid[i] = 1'b0;
      tx_data[i]  = 8'h00;
      miso[i]     = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_loopback();
    test_miso_high();
    test_lsb_first();
    test_cs_timing();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- Mode-0 SPI master sequencer driven by the serial clock generator's `sclk` and its one-`clk`-cycle edge strobes.
- Accepts a parallel word over a valid/ready handshake and frames the transfer with `cs_n`.
- Shifts data out on `mosi` at falling edges, samples `miso` at rising edges, and returns the received word as a one-cycle `rx_valid` pulse.
- Gates `sclk` so the serial clock only toggles on `sclk_out` during the data phase.

Parameters:
- WIDTH, 8, bits per transfer (2..32).
- CS_SETUP, 1, full `sclk` periods, counted in neg-edge strobes, between `cs_n` falling and the first data edge (1..15).
- CS_HOLD, 1, neg-edge strobes between the last data rising edge's following falling edge and `cs_n` rising (1..15).
- MSB_FIRST, 1, 1 = MSB shifted first; 0 = LSB first (applies to both tx and rx).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sclk_in  in  1  free-running serial clock from the generator
- sclk_pos_edge  in  1  one-cycle strobe, coincident with `sclk_in` having just gone 1
- sclk_neg_edge  in  1  one-cycle strobe, coincident with `sclk_in` having just gone 0
- tx_valid  in  1  transfer request
- tx_data  in  WIDTH  word to send; sampled only on handshake
- tx_ready  out  1  controller idle and able to accept
- rx_valid  out  1  one-cycle pulse, `rx_data` valid
- rx_data  out  WIDTH  received word; held until next `rx_valid`
- busy  out  1  high whenever state != IDLE
- cs_n  out  1  chip select, active low
- sclk_out  out  1  gated serial clock, equal to `sclk_in & xfer_active`
- mosi  out  1  serial data out
- miso  in  1  serial data in

Behaviour:
- Reset (async, `rst_n`=0): state=IDLE, `cs_n`=1, `xfer_active`=0 (so `sclk_out`=0), `mosi`=0, `tx_ready`=1, `rx_valid`=0, `rx_data`=0, `busy`=0, all counters 0. Reset mid-transfer aborts immediately: no `rx_valid`, and `cs_n` rises asynchronously.
- IDLE: `tx_ready`=1.
  - On `tx_valid & tx_ready`: latch `tx_data` into the shift register, drive first bit on `mosi`, `cs_n`<=0, setup count<=0, go SETUP.
  - `tx_ready` drops the cycle after the handshake.
- SETUP: count neg-edge strobes. On the CS_SETUP-th neg strobe: `xfer_active`<=1, bit count<=0, go XFER.
  - `xfer_active` changes only in cycles where `sclk_in`=0, so `sclk_out` is glitch-free and its first edge is a full rising edge.
- XFER:
  - Pos strobe: shift `miso` into the rx shift register; bit count++.
  - Neg strobe with bit count < WIDTH: shift the next tx bit onto `mosi`.
  - Neg strobe with bit count == WIDTH: `xfer_active`<=0, `rx_data`<=rx shift register, `rx_valid`<=1 for exactly one cycle, hold count<=0, go HOLD.
  - Exactly WIDTH rising edges appear on `sclk_out` per transfer.
- HOLD: `cs_n` stays 0. Count CS_HOLD neg strobes, where the first counted strobe is the one after HOLD entry. On the last: `cs_n`<=1, go IDLE. `tx_ready` is 1 the following cycle.
  - Minimum `cs_n`-high gap between back-to-back transfers is 1 `clk` cycle.
- Simultaneous pos and neg strobes cannot occur from the generator. If both are seen, pos is processed and neg is ignored.
- Strobes arriving in IDLE are ignored.
- `tx_valid` deasserting in any non-IDLE state has no effect.
- `mosi` holds its last value in HOLD/IDLE.
- `busy` = (state != IDLE), registered with the state.
- `rx_valid` has no backpressure; it is a pulse only.
- Bit counter width is $clog2(WIDTH+1). Setup/hold counters are 4 bits.

Decomposition:
- Shared header `serial_defs.vh` holds:
  - state encodings: IDLE=2'd0, SETUP=2'd1, XFER=2'd2, HOLD=2'd3
  - default WIDTH/CS_SETUP/CS_HOLD constants, reused by the serial clock generator's integration top
- One natural sub-module, `spi_shift_reg`:
  - WIDTH-bit tx/rx shift pair with load, shift_out (neg strobe), shift_in (pos strobe) and MSB_FIRST ordering
  - the FSM and counters stay in `spi_master_ctrl`

Test Plan:
- Generator at bits=5 (32-clk half period), WIDTH=8, `miso` looped to `mosi`, send 0xA5 -> exactly 8 rising edges on `sclk_out`; `rx_data`=0xA5; `rx_valid` high 1 cycle; `cs_n` low throughout.
- `miso` tied 1, send 0x00 -> `rx_data`=0xFF; `mosi` sampled at each `sclk_out` rise reads 0,0,0,0,0,0,0,0.
- MSB_FIRST=0, send 0x01 with external `miso` pattern 1,0,0,0,0,0,0,0 -> `mosi` first bit=1; `rx_data`=0x01.
- CS_SETUP=3, CS_HOLD=2 -> 3 neg strobes from `cs_n` fall to first `sclk_out` rise; 2 neg strobes after the final data fall before `cs_n` rises; `sclk_out` stays 0 outside XFER.
- `tx_valid` held high with two back-to-back words 0x3C then 0xC3 -> two `rx_valid` pulses with 0x3C, 0xC3; `cs_n` high at least 1 cycle between them; `tx_ready` low for the whole of each transfer.
- `rst_n` pulsed low after the 4th `sclk_out` rise -> `cs_n`=1, `sclk_out`=0 and `tx_ready`=1 immediately; no `rx_valid`; a following 0x5A transfer completes correctly.
